// File: rtl/if_fetch_queue_pkg.sv
// Shared constants for the instruction-fetch front end: default widths,
// reset PC, access size and the field layout of the IF->ID bus.
package if_fetch_queue_pkg;

    localparam int          DEF_ADDR_W   = 32;
    localparam int          DEF_DATA_W   = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h1c00_0000;
    localparam logic [1:0]  SIZE_WORD    = 2'b10;

    // if_to_id_bus = {pc, inst}: instruction in the low bits, pc above it
    localparam int BUS_INST_LSB = 0;
    localparam int BUS_PC_LSB   = DEF_DATA_W;

endpackage

// File: rtl/if_fetch_queue_sync_fifo.sv
// Small synchronous FIFO with flush; registered storage, head visible on dout_o.
// Push while full and pop while empty are ignored; flush wins over both.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (flush_i) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            if (do_push) wr_d = next_ptr(wr_q);
            if (do_pop)  rd_d = next_ptr(rd_q);
            if (do_push && !do_pop)      count_d = count_q + CW'(1);
            else if (!do_push && do_pop) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: credit-limited sram-like requests, in-order
// PC tagging of responses, skid buffer toward ID, and count-based redirect discard.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int                ADDR_W          = DEF_ADDR_W,
    parameter int                DATA_W          = DEF_DATA_W,
    parameter int                MAX_OUTSTANDING = 2,
    parameter int                BUF_DEPTH       = 4,
    parameter logic [ADDR_W-1:0] RESET_PC        = ADDR_W'(DEF_RESET_PC)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     br_taken,
    input  logic [ADDR_W-1:0]        br_target,
    output logic                     inst_sram_req,
    output logic                     inst_sram_wr,
    output logic [1:0]               inst_sram_size,
    output logic [ADDR_W-1:0]        inst_sram_addr,
    output logic [DATA_W-1:0]        inst_sram_wdata,
    input  logic                     inst_sram_addr_ok,
    input  logic                     inst_sram_data_ok,
    input  logic [DATA_W-1:0]        inst_sram_rdata,
    input  logic                     id_allowin,
    output logic                     if_to_id_valid,
    output logic [ADDR_W+DATA_W-1:0] if_to_id_bus
);

    localparam int IW = $clog2(MAX_OUTSTANDING + 1);
    localparam int BW = $clog2(BUF_DEPTH + 1);

    logic [ADDR_W-1:0]        fetch_pc_q, fetch_pc_d;
    logic [IW-1:0]            inflight_q, inflight_d;
    logic [IW-1:0]            discard_q, discard_d;
    logic [ADDR_W-1:0]        tag_pc;
    logic                     tag_full, tag_empty;
    logic [IW-1:0]            tag_count;
    logic [ADDR_W+DATA_W-1:0] buf_head;
    logic                     buf_full, buf_empty;
    logic [BW-1:0]            buf_count;
    logic [BW:0]              credit_sum;
    logic                     accept, resp, drop, buf_push, buf_pop;

    // Counting buffered plus in-flight instructions as credit means every
    // accepted response is guaranteed a free buffer slot on arrival.
    assign credit_sum = {{(BW + 1 - IW){1'b0}}, inflight_q} + {1'b0, buf_count};

    assign inst_sram_req   = resetn & ~br_taken & ~tag_full
                           & (inflight_q < IW'(MAX_OUTSTANDING))
                           & (credit_sum < (BW + 1)'(BUF_DEPTH));
    assign inst_sram_addr  = fetch_pc_q;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = SIZE_WORD;
    assign inst_sram_wdata = '0;

    assign accept   = inst_sram_req & inst_sram_addr_ok;
    assign resp     = inst_sram_data_ok & ~tag_empty;
    assign drop     = (discard_q != '0) | br_taken;
    assign buf_push = resp & ~drop;
    assign buf_pop  = if_to_id_valid & id_allowin & ~br_taken;

    assign if_to_id_valid = resetn & ~buf_empty;
    assign if_to_id_bus   = resetn ? buf_head : '0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;
        if (br_taken)    fetch_pc_d = br_target;
        else if (accept) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
        if (accept && !resp)      inflight_d = inflight_q + IW'(1);
        else if (!accept && resp) inflight_d = inflight_q - IW'(1);
        // On redirect every response still owed is stale, except one
        // arriving right now, which is dropped directly.
        if (br_taken)                      discard_d = inflight_q - IW'(resp);
        else if (resp && discard_q != '0)  discard_d = discard_q - IW'(1);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    sync_fifo #(.WIDTH(ADDR_W), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
        .clk_i   (clk),
        .rst_ni  (resetn),
        .push_i  (accept),
        .din_i   (fetch_pc_q),
        .pop_i   (resp),
        .flush_i (1'b0),
        .dout_o  (tag_pc),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .count_o (tag_count)
    );

    sync_fifo #(.WIDTH(ADDR_W + DATA_W), .DEPTH(BUF_DEPTH)) u_inst_buf (
        .clk_i   (clk),
        .rst_ni  (resetn),
        .push_i  (buf_push),
        .din_i   ({tag_pc, inst_sram_rdata}),
        .pop_i   (buf_pop),
        .flush_i (br_taken),
        .dout_o  (buf_head),
        .full_o  (buf_full),
        .empty_o (buf_empty),
        .count_o (buf_count)
    );

    a_no_orphan_data_ok: assert property (@(posedge clk) disable iff (!resetn)
        inst_sram_data_ok |-> (inflight_q != '0))
        else $error("data_ok with no request in flight");
    a_buf_room: assert property (@(posedge clk) disable iff (!resetn)
        buf_push |-> !buf_full)
        else $error("response arrived with instruction buffer full");
    a_tag_track: assert property (@(posedge clk) disable iff (!resetn)
        tag_count == inflight_q)
        else $error("tag FIFO occupancy disagrees with inflight count");

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomised bench for if_fetch_queue: a memory responder plus a queue-based
// reference model of the fetch front end, stepped once per clock.
module tb_if_fetch_queue;

    localparam int          MAXO   = 2;
    localparam int          BUFD   = 4;
    localparam logic [31:0] RST_PC = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        resetn, br_taken;
    logic [31:0] br_target;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        id_allowin, if_to_id_valid;
    logic [63:0] if_to_id_bus;

    if_fetch_queue #(
        .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(MAXO), .BUF_DEPTH(BUFD), .RESET_PC(RST_PC)
    ) dut (
        .clk(clk), .resetn(resetn), .br_taken(br_taken), .br_target(br_target),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata), .inst_sram_addr_ok(inst_sram_addr_ok),
        .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
        .id_allowin(id_allowin), .if_to_id_valid(if_to_id_valid), .if_to_id_bus(if_to_id_bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5a5a_1234;
    endfunction

    // Reference model: fetch PC, accepted-unanswered addresses, discard count, buffer.
    logic [31:0] m_pc;
    logic [31:0] m_infl[$];
    int          m_disc;
    logic [63:0] m_buf[$];
    logic [31:0] mem_q[$];
    int          stream_valid;

    task automatic step(input int pa, input int pd, input int pal, input int pbr, input int prst);
        logic        exp_req, exp_valid, acc, resp, drp, pop;
        logic [31:0] ra, tgt;
        int          old_n;
        @(negedge clk);
        resetn   = !($urandom_range(99) < prst);
        br_taken = resetn && ($urandom_range(99) < pbr);
        tgt = $urandom;
        tgt[1:0] = 2'b00;
        br_target = ($urandom_range(7) == 0) ? 32'hffff_fff8 : tgt;
        inst_sram_addr_ok = ($urandom_range(99) < pa);
        inst_sram_data_ok = resetn && (mem_q.size() > 0) && ($urandom_range(99) < pd);
        inst_sram_rdata   = inst_sram_data_ok ? mem_fn(mem_q[0]) : $urandom;
        id_allowin        = ($urandom_range(99) < pal);
        #1;
        exp_req   = resetn && !br_taken && (m_infl.size() < MAXO)
                    && (m_infl.size() + m_buf.size() < BUFD);
        exp_valid = resetn && (m_buf.size() > 0);
        check_eq("req", 64'(inst_sram_req), 64'(exp_req));
        if (exp_req) check_eq("addr", 64'(inst_sram_addr), 64'(m_pc));
        check_eq("valid", 64'(if_to_id_valid), 64'(exp_valid));
        if (exp_valid) check_eq("bus", if_to_id_bus, m_buf[0]);
        if (!resetn) check_eq("bus_rst", if_to_id_bus, 64'h0);
        check_eq("const", 64'({inst_sram_wr, inst_sram_size, inst_sram_wdata}), 64'({1'b0, 2'b10, 32'h0}));
        if (if_to_id_valid) stream_valid++;

        // memory side follows what the DUT actually presented
        if (!resetn) mem_q.delete();
        else begin
            if (inst_sram_data_ok) void'(mem_q.pop_front());
            if (inst_sram_req && inst_sram_addr_ok) mem_q.push_back(inst_sram_addr);
        end

        if (!resetn) begin
            m_pc = RST_PC;
            m_infl.delete();
            m_buf.delete();
            m_disc = 0;
        end else begin
            acc   = exp_req && inst_sram_addr_ok;
            resp  = inst_sram_data_ok && (m_infl.size() > 0);
            old_n = m_infl.size();
            ra    = resp ? m_infl.pop_front() : 32'h0;
            drp   = (m_disc > 0) || br_taken;
            pop   = exp_valid && id_allowin && !br_taken;
            if (br_taken) m_buf.delete();
            else if (pop) void'(m_buf.pop_front());
            if (resp && !drp) m_buf.push_back({ra, mem_fn(ra)});
            if (br_taken) m_disc = old_n - int'(resp);
            else if (resp && m_disc > 0) m_disc--;
            if (acc) m_infl.push_back(m_pc);
            if (br_taken) m_pc = br_target;
            else if (acc) m_pc = m_pc + 32'd4;
        end
    endtask

    // phase knobs: cycles, addr_ok %, data_ok %, allowin %, br %, reset %
    int ph_len[8] = '{3, 150, 40, 40, 40, 40, 2500, 800};
    int ph_a[8]   = '{0, 100, 100, 100, 100, 100, 70, 100};
    int ph_d[8]   = '{0, 100, 100, 100, 0, 100, 60, 50};
    int ph_al[8]  = '{0, 100, 0, 100, 100, 100, 70, 30};
    int ph_br[8]  = '{0, 0, 0, 0, 0, 0, 8, 15};
    int ph_rs[8]  = '{100, 0, 0, 0, 0, 0, 1, 0};

    initial begin
        resetn = 1'b0; br_taken = 1'b0; br_target = '0;
        inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0;
        inst_sram_rdata = '0; id_allowin = 1'b0;
        m_pc = RST_PC; m_disc = 0;
        for (int p = 0; p < 8; p++) begin
            stream_valid = 0;
            for (int c = 0; c < ph_len[p]; c++) begin
                if (p == 1 && c == 5) stream_valid = 0;
                step(ph_a[p], ph_d[p], ph_al[p], ph_br[p], ph_rs[p]);
            end
            // fully ready memory and ID sustain one instruction per cycle
            if (p == 1) check_eq("stream_rate", 64'(stream_valid), 64'(ph_len[1] - 5));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Parametrised instruction-fetch front end for the 5-stage pipeline. It replaces the fixed single-cycle inst SRAM port with an sram-like req/addr_ok/data_ok interface and supports up to MAX_OUTSTANDING in-flight requests. Returned instructions go into a BUF_DEPTH skid buffer that feeds ID through the valid/allowin handshake. Branch redirects discard stale in-flight responses by count.

Parameters:
ADDR_W, 32, PC/address width
DATA_W, 32, instruction width
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered requests (power of 2, >=1)
BUF_DEPTH, 4, instruction buffer entries (power of 2, >= MAX_OUTSTANDING)
RESET_PC, 32'h1c000000, first fetch address after reset

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
br_taken  in  1  one-cycle redirect pulse from ID
br_target  in  ADDR_W  redirect PC
inst_sram_req  out  1  request valid
inst_sram_wr  out  1  constant 0
inst_sram_size  out  2  constant 2'b10 (word)
inst_sram_addr  out  ADDR_W  fetch PC
inst_sram_wdata  out  DATA_W  constant 0
inst_sram_addr_ok  in  1  request accepted this cycle
inst_sram_data_ok  in  1  response valid this cycle (in order)
inst_sram_rdata  in  DATA_W  response data
id_allowin  in  1  ID can accept
if_to_id_valid  out  1  buffer head valid
if_to_id_bus  out  ADDR_W+DATA_W  {pc, inst} of buffer head

Behaviour:
- Reset (resetn=0 at posedge): fetch_pc<=RESET_PC; inflight, discard_cnt, buffer and PC-tag FIFO empty. While resetn=0: inst_sram_req=0, if_to_id_valid=0, if_to_id_bus=0.
- Issue condition (combinational): req = resetn & ~br_taken & (inflight < MAX_OUTSTANDING) & (inflight + buf_count < BUF_DEPTH). This credit rule guarantees that no accepted response ever finds the buffer full.
- inst_sram_addr=fetch_pc. The protocol permits withdrawing a not-yet-accepted req, so masking it on br_taken is legal.
- Accept (req & addr_ok): push fetch_pc into the tag FIFO; fetch_pc<=fetch_pc+4 (wraps mod 2^ADDR_W); inflight+1.
- Response (data_ok): pop the tag FIFO; inflight-1.
  - If discard_cnt>0 (or br_taken this cycle): drop the data; discard_cnt-1 when it was >0.
  - Otherwise push {tag_pc, rdata} into the buffer. It is visible on if_to_id_valid the next cycle (1-cycle latency, no bypass).
- data_ok while inflight==0 is a protocol error: ignore it and assert in simulation.
- Pop: if_to_id_valid & id_allowin removes the head. Simultaneous push and pop keeps buf_count unchanged.
- Redirect (br_taken=1 at posedge):
  - fetch_pc<=br_target.
  - The buffer is flushed and if_to_id_valid=0 the next cycle.
  - discard_cnt<=inflight - data_ok_this_cycle. That response is dropped, and no accept can occur because req is masked.
  - The tag FIFO is kept; its entries drain with the discarded responses.
  - A pop in the same cycle is ignored, since the flush wins.
- br_taken while discard_cnt>0: new discard_cnt=inflight-data_ok. All in-flight responses are stale.
- Steady state, with addr_ok and data_ok 1 cycle after accept: 1 instruction/cycle.

Decomposition:
- Shared package: ADDR_W/DATA_W defaults, RESET_PC, SIZE_WORD=2'b10, if_to_id_bus field offsets (pc high, inst low).
- One sub-module: sync_fifo (params WIDTH, DEPTH; push/pop/flush/full/empty/count). Instantiated twice: tag FIFO (ADDR_W x MAX_OUTSTANDING) and instruction buffer ((ADDR_W+DATA_W) x BUF_DEPTH).
- Counters and the issue/discard logic stay in if_fetch_queue.

Test Plan:
1. Release reset with addr_ok=1, data_ok 1 cycle after accept, id_allowin=1 -> addresses 0x1c000000, 0x1c000004, 0x1c000008 issued on consecutive cycles; if_to_id_bus pcs appear in order, 1 per cycle, paired with the matching rdata.
2. Hold id_allowin=0 with the memory always ready -> exactly BUF_DEPTH=4 accepts total, then req=0; raising id_allowin drains 0x1c000000..0x1c00000c in order and issue resumes.
3. Hold data_ok=0 -> req drops after 2 accepts (MAX_OUTSTANDING); inflight never exceeds 2.
4. Two requests in flight, then br_taken with br_target=0x1c000100 -> both responses dropped, buffer flushed; next delivered pc=0x1c000100 with its own data.
5. br_taken in the same cycle as a data_ok, one other request in flight -> that data_ok is dropped, discard_cnt=1, the next response is dropped, and the first delivered pc=br_target.
6. Assert resetn=0 mid-stream with 2 in flight and a full buffer -> next cycle req=0, if_to_id_valid=0; after release the first address is 0x1c000000.
